// File: rtl/alu_serial.sv
// alu_serial: digit-serial NOR/XOR/ADD/SUB ALU, DIGIT bits per clock LSB first
// Ports: clk; rst_n async active-low; start/op/a/b request (sampled in IDLE/DONE);
//        busy high during RUN; done one-cycle pulse; s result; cout, ovf, zero flags.
// Define ALU_FLAGS_EN to compute ovf and zero; otherwise both are tied to 0.
`timescale 1ns/1ps
module alu_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int K = WIDTH / DIGIT;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb, acc, nxt;
  logic [1:0] rop;
  logic [CW-1:0] cnt;
  logic carry, arith, last;
  logic [DIGIT-1:0] da, db, dbx, dig;
  logic [DIGIT:0] sum;
  always_comb begin
    arith = rop[1];
    da = ra[DIGIT-1:0];
    db = rb[DIGIT-1:0];
    dbx = rop[0] ? ~db : db;
    sum = {1'b0, da} + {1'b0, dbx} + {{DIGIT{1'b0}}, carry};
    dig = arith ? sum[DIGIT-1:0] : rop[0] ? da ^ db : ~(da | db);
    nxt = WIDTH'({dig, acc} >> DIGIT);
    last = cnt == CW'(K - 1);
  end
`ifdef ALU_FLAGS_EN
  // carry into the top bit of the digit, recovered from its sum bit
  logic msb_cin;
  assign msb_cin = sum[DIGIT-1] ^ da[DIGIT-1] ^ dbx[DIGIT-1];
`else
  assign ovf = 1'b0;
  assign zero = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      s <= '0;
      cout <= 1'b0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      rop <= '0;
      cnt <= '0;
      carry <= 1'b0;
`ifdef ALU_FLAGS_EN
      ovf <= 1'b0;
      zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        acc <= nxt;
        ra <= ra >> DIGIT;
        rb <= rb >> DIGIT;
        carry <= arith & sum[DIGIT];
        cnt <= cnt + CW'(1);
        if (last) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          s <= nxt;
          cout <= arith & sum[DIGIT];
`ifdef ALU_FLAGS_EN
          ovf <= arith & (msb_cin ^ sum[DIGIT]);
          zero <= nxt == '0;
`endif
        end
      end else if (start) begin
        state <= RUN;
        busy <= 1'b1;
        ra <= a;
        rb <= b;
        rop <= op;
        acc <= '0;
        cnt <= '0;
        carry <= &op;
      end else
        state <= IDLE;
    end
endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised multi-cycle ALU that generalises the 1-bit ALU cell to WIDTH-bit operands. It processes DIGIT bits per clock, LSB first, with a ripple carry held in a flop between cycles. A start/busy/done handshake lets a controller issue NOR, XOR, ADD and SUB while trading latency against area. Final result and flags are registered and held until the next operation completes.

## Interface
- WIDTH, 8, operand/result width in bits; at least 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH evenly. K = WIDTH/DIGIT.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  00 NOR, 01 XOR, 10 ADD (a+b), 11 SUB (a-b); sampled with start.
- a  input  WIDTH  operand a; sampled with start.
- b  input  WIDTH  operand b; sampled with start.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse when s and the flags update.
- s  output  WIDTH  result register.
- cout  output  1  ADD: carry out. SUB: not-borrow (1 when a >= b unsigned). NOR/XOR: 0.
- ovf  output  1  signed overflow for ADD/SUB; 0 for NOR/XOR.
- zero  output  1  1 when s == 0.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: computing.
  - DONE: result published.
- Transitions:
  - IDLE, start = 1: go to RUN. Capture a, b and op into shift registers. Clear the digit counter. Initialise the carry flop to op == 11 (1 for SUB, 0 otherwise).
  - RUN, each cycle: combine the low DIGIT bits of a and b with the carry flop. Shift the result digit into the partial-result register (MSB-side entry). Shift a and b right by DIGIT. Update the carry flop. Increment the counter.
  - RUN, counter == K-1: go to DONE. In the same edge, load s, cout, ovf and zero from the completed result.
  - DONE, start = 1: go to RUN with a new capture (back-to-back issue).
  - DONE, start = 0: go to IDLE.
- Digit operation per op code:
  - NOR: ~(a|b).
  - XOR: a^b.
  - ADD: a+b+c.
  - SUB: a+~b+c.
  - The carry chain is used only for ADD and SUB. For NOR and XOR the carry flop is held at 0.
- Overflow: ovf = carry into the MSB XOR carry out of the MSB. Track the MSB carry-in inside the last digit.
- start is ignored in RUN. Input changes during RUN have no effect.
- s, cout, ovf and zero change only at the edge entering DONE, or on reset. They hold otherwise, including through IDLE.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system): state goes to IDLE. busy, done, s, cout, ovf and zero are all 0. Internal shift registers and the counter clear.
- Reset mid-RUN aborts the operation. No done pulse is produced and the previous s is lost (s = 0).
- Latency: start sampled at edge E0. busy is high from E0 to E_K. done is high for the single cycle between E_K and E_(K+1).
  - WIDTH=8, DIGIT=1: done in the 8th cycle after the start edge.
  - WIDTH=8, DIGIT=4: done in the 2nd cycle.
- Throughput with back-to-back starts: one result every K+1 cycles.
- busy and done are never high in the same cycle. done is never high for two consecutive cycles, even back-to-back.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- ALU_FLAGS_EN defined: ovf and zero are computed and registered as described.
- ALU_FLAGS_EN undefined:
  - ovf and zero are tied to constant 0 and their flops are removed.
  - MSB carry-in tracking is removed.
  - s, cout and the handshake are unchanged.

## Test plan
- WIDTH=8, DIGIT=1, ADD a=0x7F b=0x01 -> s=0x80, cout=0, ovf=1, zero=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
- SUB a=0x05 b=0x07 -> s=0xFE, cout=0, ovf=0. SUB a=0x80 b=0x01 -> s=0x7F, cout=1, ovf=1.
- NOR a=0xF0 b=0x0F -> s=0x00, zero=1, cout=0. XOR a=0xAA b=0xFF -> s=0x55, zero=0.
- DIGIT=4, ADD a=0xFF b=0x01 -> s=0x00, cout=1, zero=1, done 2 cycles after start. Then hold start high in the DONE cycle with SUB 0x10-0x10 -> s=0x00, cout=1, second done 3 cycles after the first.
- start pulsed with new operands mid-RUN -> ignored; the original result is published and no extra done follows.
- rst_n low for 1 cycle mid-RUN -> immediate IDLE, all outputs 0, no done. A fresh start then completes normally.
- Without ALU_FLAGS_EN: repeat the first scenario -> s=0x80, cout=0, ovf=0, zero=0.
